// File: rtl/boot_word_packer_pkg.sv
// Shared types for the boot word packer: the queued word entry, the merge-buffer
// state encoding and a byte-lane merge helper.
package boot_pack_pkg;

    typedef struct packed {
        logic [29:0] base;
        logic [31:0] data;
        logic [3:0]  be;
    } word_entry_t;

    typedef enum logic {PK_EMPTY, PK_PARTIAL} pack_state_t;

    localparam logic [3:0] FULL_BE = 4'hF;

    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        r[8*lane +: 8] = data;
        return r;
    endfunction

endpackage

// File: rtl/boot_word_packer_fifo.sv
// Synchronous FIFO of word entries accepting up to two pushes and one pop per
// cycle; entry 0 is written ahead of entry 1 so order is preserved.
module boot_word_fifo
    import boot_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            i_push0,
    input  word_entry_t     i_din0,
    input  logic            i_push1,
    input  word_entry_t     i_din1,
    input  logic            i_pop,
    output word_entry_t     o_head,
    output logic            o_empty,
    output logic            o_full,
    output logic [CW-1:0]   o_count
);

    word_entry_t   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_npush;

    assign w_npush = CW'(i_push0) + CW'(i_push1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_npush);
            r_rd  <= r_rd + AW'(i_pop);
            r_cnt <= r_cnt + w_npush - CW'(i_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (i_push0) r_mem[r_wr] <= i_din0;
        if (i_push1) r_mem[r_wr + AW'(1)] <= i_din1;
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(FIFO_DEPTH));
    assign o_count = r_cnt;

endmodule

// File: rtl/boot_word_packer.sv
// Merges single-byte loader writes into full 32-bit word writes, queued toward
// instruction memory. Optional running byte checksum: define BOOT_PACK_CSUM_EN.
module boot_word_packer
    import boot_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             byte_we,
    input  logic [31:0]      byte_addr,
    input  logic [7:0]       byte_data,
    input  logic             flush,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    output logic             busy,
    output logic             ovf_err,
    output logic [CNT_W-1:0] word_cnt
`ifdef BOOT_PACK_CSUM_EN
    ,
    output logic [31:0]      csum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pack_state_t r_state;
    logic [29:0] r_base;
    logic [31:0] r_wbuf;
    logic [3:0]  r_bbuf;
    logic        r_ovf;
    logic [CNT_W-1:0] r_cnt;

    pack_state_t w_nstate;
    logic [29:0] w_nbase;
    logic [31:0] w_nwbuf;
    logic [3:0]  w_nbbuf;
    logic [1:0]  w_lane;
    logic [1:0]  w_need;
    logic        w_ok;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    word_entry_t w_e0;
    word_entry_t w_e1;
    word_entry_t w_head;

    assign w_lane = byte_addr[1:0];
    assign w_pop  = !w_empty && mem_gnt;
    assign w_free = w_full ? CW'(w_pop) : CW'(FIFO_DEPTH) - w_count + CW'(w_pop);
    assign w_ok   = (CW'(w_need) <= w_free);

    always_comb begin
        w_need   = 2'd0;
        w_e0     = '{base: r_base, data: r_wbuf, be: r_bbuf};
        w_e1     = w_e0;
        w_nstate = r_state;
        w_nbase  = r_base;
        w_nwbuf  = r_wbuf;
        w_nbbuf  = r_bbuf;
        if (byte_we) begin
            if (r_state == PK_PARTIAL &&
                (r_base != byte_addr[31:2] || r_bbuf[w_lane])) begin
                // Conflict: old buffer goes out as entry 0, new byte restarts it.
                w_need   = 2'd1;
                w_nbase  = byte_addr[31:2];
                w_nwbuf  = merge_byte('0, w_lane, byte_data);
                w_nbbuf  = 4'b0001 << w_lane;
                w_nstate = PK_PARTIAL;
                if (flush) begin
                    w_need   = 2'd2;
                    w_e1     = '{base: w_nbase, data: w_nwbuf, be: w_nbbuf};
                    w_nstate = PK_EMPTY;
                end
            end else begin
                w_nbase  = (r_state == PK_EMPTY) ? byte_addr[31:2] : r_base;
                w_nwbuf  = merge_byte((r_state == PK_EMPTY) ? '0 : r_wbuf,
                                      w_lane, byte_data);
                w_nbbuf  = ((r_state == PK_EMPTY) ? 4'b0000 : r_bbuf) |
                           (4'b0001 << w_lane);
                w_nstate = PK_PARTIAL;
                if (w_nbbuf == FULL_BE || flush) begin
                    w_need   = 2'd1;
                    w_e0     = '{base: w_nbase, data: w_nwbuf, be: w_nbbuf};
                    w_nstate = PK_EMPTY;
                end
            end
        end else if (flush && r_state == PK_PARTIAL) begin
            w_need   = 2'd1;
            w_nstate = PK_EMPTY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= PK_EMPTY;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_ok) r_state <= w_nstate;
            if (byte_we && !w_ok) r_ovf <= 1'b1;
            r_cnt <= r_cnt + CNT_W'(w_pop);
        end
    end

    // A rejected operation leaves the buffer exactly as it was.
    always_ff @(posedge Clk) begin
        if (w_ok) begin
            r_base <= w_nbase;
            r_wbuf <= w_nwbuf;
            r_bbuf <= w_nbbuf;
        end
    end

`ifdef BOOT_PACK_CSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge Clk) begin
        if (Rst)                 r_csum <= '0;
        else if (byte_we && w_ok) r_csum <= r_csum + {24'b0, byte_data};
    end

    assign csum = r_csum;
`endif

    boot_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_push0 (w_ok && w_need != 2'd0),
        .i_din0  (w_e0),
        .i_push1 (w_ok && w_need == 2'd2),
        .i_din1  (w_e1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign mem_req   = !w_empty;
    assign mem_we    = !w_empty;
    assign mem_addr  = w_empty ? 32'h0 : {w_head.base, 2'b00};
    assign mem_wdata = w_empty ? 32'h0 : w_head.data;
    assign mem_be    = w_empty ? 4'h0  : w_head.be;
    assign busy      = (r_state == PK_PARTIAL) || !w_empty;
    assign ovf_err   = r_ovf;
    assign word_cnt  = r_cnt;

endmodule
